// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing and types for the register write scoreboard.
package reg_scoreboard_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/reg_scoreboard_counter.sv
// Saturating-by-construction pending-write counter for one register.
module reg_scoreboard_counter
  import reg_scoreboard_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output cnt_t count_o,
  output logic nonzero_o,
  output logic at_max_o
);

  cnt_t count_q, count_d;

  // Next count: clear wins, simultaneous inc/dec cancel; caller never incs at max without a dec.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i) begin
      count_d = count_q + cnt_t'(1);
    end else if (dec_i && !inc_i) begin
      count_d = count_q - cnt_t'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign nonzero_o = (count_q != '0);
  assign at_max_o  = (count_q == cnt_t'(CNT_MAX));

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks outstanding register writes between issue and writeback, and raises Stall for RAW
// hazards or when a destination's pending-write counter is full.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                IssueValid,
  input  logic [ADDR_W-1:0]   IssueRs,
  input  logic [ADDR_W-1:0]   IssueRt,
  input  logic                IssueUsesRt,
  input  logic                IssueWrEn,
  input  logic [ADDR_W-1:0]   IssueDst,
  input  logic                WbValid,
  input  logic [ADDR_W-1:0]   WbDst,
  input  logic                Flush,
  output logic                Stall,
  output logic                IssueAccept,
  output logic [NUM_REGS-1:0] BusyMask,
  output logic                Underflow
);

  cnt_t                cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nonzero;
  logic [NUM_REGS-1:0] at_max;
  logic [NUM_REGS-1:1] inc;
  logic [NUM_REGS-1:1] dec;
  logic                haz_rs, haz_rt, full_dst, uf_set;
  logic                underflow_q;

  // A source is hazardous while it has pending writes, unless the last one retires this cycle.
  function automatic logic src_hazard(reg_idx_t src, cnt_t src_cnt, logic wb_hit);
    logic bypass;
    bypass = WB_BYPASS && wb_hit && (src_cnt == cnt_t'(1));
    return (src != reg_idx_t'(REG_ZERO)) && (src_cnt != '0) && !bypass;
  endfunction

  // Register 0 is never tracked.
  assign cnt[0]     = '0;
  assign nonzero[0] = 1'b0;
  assign at_max[0]  = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    reg_scoreboard_counter u_cnt (
      .clk_i     (Clk),
      .rst_ni    (Reset),
      .inc_i     (inc[i]),
      .dec_i     (dec[i]),
      .clr_i     (Flush),
      .count_o   (cnt[i]),
      .nonzero_o (nonzero[i]),
      .at_max_o  (at_max[i])
    );
  end

  // Hazard and stall decision for the instruction presented by decode.
  always_comb begin
    haz_rs      = src_hazard(IssueRs, cnt[IssueRs], WbValid && (WbDst == IssueRs));
    haz_rt      = src_hazard(IssueRt, cnt[IssueRt], WbValid && (WbDst == IssueRt));
    // A full counter can still take one more write if a writeback frees a slot this cycle.
    full_dst    = IssueWrEn && (IssueDst != reg_idx_t'(REG_ZERO)) && at_max[IssueDst] &&
                  !(WbValid && (WbDst == IssueDst));
    Stall       = IssueValid && (haz_rs || (IssueUsesRt && haz_rt) || full_dst);
    IssueAccept = IssueValid && !Stall;
  end

  // Per-register increment on accepted issue, decrement on writeback of a pending register.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      inc[i] = IssueAccept && IssueWrEn && (IssueDst == reg_idx_t'(i));
      dec[i] = WbValid && (WbDst == reg_idx_t'(i)) && nonzero[i];
    end
  end

  assign uf_set = WbValid && !Flush && (WbDst != reg_idx_t'(REG_ZERO)) && !nonzero[WbDst];

  // Sticky underflow flag; only reset clears it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      underflow_q <= 1'b0;
    end else if (uf_set) begin
      underflow_q <= 1'b1;
    end
  end

  assign BusyMask  = nonzero;
  assign Underflow = underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IssueValid, IssueUsesRt, IssueWrEn, WbValid, Flush;
  logic [4:0]  IssueRs, IssueRt, IssueDst, WbDst;
  logic        Stall, IssueAccept, Underflow;
  logic [31:0] BusyMask;
  logic        Stall_nb, IssueAccept_nb, Underflow_nb;
  logic [31:0] BusyMask_nb;

  always #5 Clk = ~Clk;

  reg_scoreboard #(.WB_BYPASS(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .IssueValid(IssueValid), .IssueRs(IssueRs), .IssueRt(IssueRt),
    .IssueUsesRt(IssueUsesRt), .IssueWrEn(IssueWrEn), .IssueDst(IssueDst), .WbValid(WbValid),
    .WbDst(WbDst), .Flush(Flush), .Stall(Stall), .IssueAccept(IssueAccept),
    .BusyMask(BusyMask), .Underflow(Underflow)
  );

  reg_scoreboard #(.WB_BYPASS(1'b0)) dut_nb (
    .Clk(Clk), .Reset(Reset), .IssueValid(IssueValid), .IssueRs(IssueRs), .IssueRt(IssueRt),
    .IssueUsesRt(IssueUsesRt), .IssueWrEn(IssueWrEn), .IssueDst(IssueDst), .WbValid(WbValid),
    .WbDst(WbDst), .Flush(Flush), .Stall(Stall_nb), .IssueAccept(IssueAccept_nb),
    .BusyMask(BusyMask_nb), .Underflow(Underflow_nb)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rs, rt;
    logic        ut, we;
    logic [4:0]  dst;
    logic        wbv;
    logic [4:0]  wbd;
    logic        fl;
    logic        stall, stall_nb;
    logic [31:0] busy;
    logic        uf;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] busy;
    logic        uf;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] b(input int n);
    return 32'd1 << n;
  endfunction

  task automatic add(input string name, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic ut, input logic we, input logic [4:0] dst, input logic wbv,
                     input logic [4:0] wbd, input logic fl, input logic stall,
                     input logic stall_nb, input logic [31:0] busy, input logic uf);
    vec_t x;
    x.name = name; x.v = v; x.rs = rs; x.rt = rt; x.ut = ut; x.we = we; x.dst = dst;
    x.wbv = wbv; x.wbd = wbd; x.fl = fl; x.stall = stall; x.stall_nb = stall_nb;
    x.busy = busy; x.uf = uf;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    IssueValid = x.v; IssueRs = x.rs; IssueRt = x.rt; IssueUsesRt = x.ut; IssueWrEn = x.we;
    IssueDst = x.dst; WbValid = x.wbv; WbDst = x.wbd; Flush = x.fl;
  endtask

  initial begin
    vec_t idle;
    exp_t e;
    idle = '{v: 0, rs: 0, rt: 0, ut: 0, we: 0, dst: 0, wbv: 0, wbd: 0, fl: 0,
             stall: 0, stall_nb: 0, busy: 0, uf: 0, name: "idle"};
    // name            v  rs rt ut we dst wbv wbd fl  st nb  busy after        uf
    add("raw_issue",   1, 0, 0, 0, 1, 8,  0, 0,  0,  0, 0, b(8),            0);
    add("raw_wait1",   1, 8, 0, 0, 0, 0,  0, 0,  0,  1, 1, b(8),            0);
    add("raw_wait2",   1, 8, 0, 0, 0, 0,  0, 0,  0,  1, 1, b(8),            0);
    add("raw_wb",      1, 8, 0, 0, 0, 0,  1, 8,  0,  0, 1, 0,               0);
    add("raw_after",   1, 8, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0,               0);
    add("r0_issue",    1, 0, 0, 0, 1, 0,  0, 0,  0,  0, 0, 0,               0);
    add("r0_read",     1, 0, 0, 1, 0, 0,  0, 0,  0,  0, 0, 0,               0);
    add("r0_wb",       0, 0, 0, 0, 0, 0,  1, 0,  0,  0, 0, 0,               0);
    add("sat_1",       1, 0, 0, 0, 1, 5,  0, 0,  0,  0, 0, b(5),            0);
    add("sat_2",       1, 0, 0, 0, 1, 5,  0, 0,  0,  0, 0, b(5),            0);
    add("sat_3",       1, 0, 0, 0, 1, 5,  0, 0,  0,  0, 0, b(5),            0);
    add("sat_full",    1, 0, 0, 0, 1, 5,  0, 0,  0,  1, 1, b(5),            0);
    add("sat_wb_same", 1, 0, 0, 0, 1, 5,  1, 5,  0,  0, 0, b(5),            0);
    add("sat_still",   1, 0, 0, 0, 1, 5,  0, 0,  0,  1, 1, b(5),            0);
    add("sat_drain1",  0, 0, 0, 0, 0, 0,  1, 5,  0,  0, 0, b(5),            0);
    add("sat_drain2",  1, 5, 0, 0, 0, 0,  1, 5,  0,  1, 1, b(5),            0);
    add("sat_drain3",  1, 5, 0, 0, 0, 0,  1, 5,  0,  0, 1, 0,               0);
    add("sim_issue",   1, 0, 0, 0, 1, 9,  0, 0,  0,  0, 0, b(9),            0);
    add("sim_incdec",  1, 0, 9, 0, 1, 9,  1, 9,  0,  0, 0, b(9),            0);
    add("sim_rt_use",  1, 0, 9, 1, 0, 0,  0, 0,  0,  1, 1, b(9),            0);
    add("sim_drain",   0, 0, 0, 0, 0, 0,  1, 9,  0,  0, 0, 0,               0);
    add("fl_i3",       1, 0, 0, 0, 1, 3,  0, 0,  0,  0, 0, b(3),            0);
    add("fl_i7a",      1, 0, 0, 0, 1, 7,  0, 0,  0,  0, 0, b(3) | b(7),     0);
    add("fl_i7b",      1, 0, 0, 0, 1, 7,  0, 0,  0,  0, 0, b(3) | b(7),     0);
    add("fl_flush",    0, 0, 0, 0, 0, 0,  1, 3,  1,  0, 0, 0,               0);
    add("fl_rs7",      1, 7, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0,               0);
    add("fl_wb_noUf",  0, 0, 0, 0, 0, 0,  1, 7,  1,  0, 0, 0,               0);
    add("uf_set",      0, 0, 0, 0, 0, 0,  1, 7,  0,  0, 0, 0,               1);
    add("uf_sticky",   0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0,               1);
    add("fl_drop_iss", 1, 0, 0, 0, 1, 4,  0, 0,  1,  0, 0, 0,               1);
    add("pre_rst_i12", 1, 0, 0, 0, 1, 12, 0, 0,  0,  0, 0, b(12),           1);
    add("pre_rst_rt",  1, 0, 12, 1, 0, 0, 0, 0,  0,  1, 1, b(12),           1);

    // Reset state
    drive(idle);
    Reset = 1'b0;
    #2;
    IssueValid = 1'b1; IssueRs = 5'd8; IssueRt = 5'd8; IssueUsesRt = 1'b1;
    IssueWrEn = 1'b1; IssueDst = 5'd8;
    #1;
    chk("rst_busy", BusyMask, 0);
    chk("rst_uf", {31'd0, Underflow}, 0);
    chk("rst_stall", {31'd0, Stall}, 0);
    chk("rst_accept", {31'd0, IssueAccept}, 1);
    drive(idle);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    foreach (vecs[k]) begin
      drive(vecs[k]);
      @(negedge Clk);
      chk({vecs[k].name, ".stall"}, {31'd0, Stall}, {31'd0, vecs[k].stall});
      chk({vecs[k].name, ".stall_nb"}, {31'd0, Stall_nb}, {31'd0, vecs[k].stall_nb});
      chk({vecs[k].name, ".accept"}, {31'd0, IssueAccept},
          {31'd0, vecs[k].v & ~vecs[k].stall});
      chk({vecs[k].name, ".accept_nb"}, {31'd0, IssueAccept_nb},
          {31'd0, vecs[k].v & ~vecs[k].stall_nb});
      sbq.push_back('{busy: vecs[k].busy, uf: vecs[k].uf, name: vecs[k].name});
      @(posedge Clk);
      #1;
      if (sbq.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk({e.name, ".busy"}, BusyMask, e.busy);
        chk({e.name, ".busy_nb"}, BusyMask_nb, e.busy);
        chk({e.name, ".uf"}, {31'd0, Underflow}, {31'd0, e.uf});
        chk({e.name, ".uf_nb"}, {31'd0, Underflow_nb}, {31'd0, e.uf});
      end
    end

    // Mid-cycle reset with reg 12 pending and Underflow set: clears immediately
    IssueValid = 1'b1; IssueRs = 5'd12; IssueRt = 5'd0; IssueUsesRt = 1'b0;
    IssueWrEn = 1'b0; IssueDst = 5'd0; WbValid = 1'b0; Flush = 1'b0;
    #1;
    chk("midrst_pre_stall", {31'd0, Stall}, 1);
    #1;
    Reset = 1'b0;
    #1;
    chk("midrst_busy", BusyMask, 0);
    chk("midrst_busy_nb", BusyMask_nb, 0);
    chk("midrst_uf", {31'd0, Underflow}, 0);
    chk("midrst_stall", {31'd0, Stall}, 0);
    chk("midrst_accept", {31'd0, IssueAccept}, 1);
    @(negedge Clk);
    Reset = 1'b1;
    drive(idle);
    @(posedge Clk);
    #1;
    chk("postrst_busy", BusyMask, 0);
    chk("postrst_uf", {31'd0, Underflow}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
